// File: rtl/axil_pkg.sv
// Shared constants, types and address decode for the AXI4-Lite register bank.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;

  typedef enum logic [1:0] {W_IDLE, W_GOT_ADDR, W_GOT_DATA, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} rd_state_t;

  // Out-of-range or non-word-aligned addresses are decode errors.
  function automatic logic addr_err(addr_t addr, int unsigned n_regs);
    return (addr >= addr_t'(4 * n_regs)) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/axil_if.sv
// AXI4-Lite bus bundle; master drives requests, slave drives readies and responses.
interface axil_if;
  import axil_pkg::*;

  logic       AWvalid;
  logic       AWready;
  addr_t      AWaddr;
  logic       Wvalid;
  logic       Wready;
  data_t      Wdata;
  strb_t      Wstrb;
  logic       Bvalid;
  logic       Bready;
  logic [1:0] Bresp;
  logic       ARvalid;
  logic       ARready;
  addr_t      ARaddr;
  logic       Rvalid;
  logic       Rready;
  data_t      Rdata;
  logic [1:0] Rresp;

  modport master (
    output AWvalid, AWaddr, Wvalid, Wdata, Wstrb, Bready, ARvalid, ARaddr, Rready,
    input  AWready, Wready, Bvalid, Bresp, ARready, Rvalid, Rdata, Rresp
  );

  modport slave (
    input  AWvalid, AWaddr, Wvalid, Wdata, Wstrb, Bready, ARvalid, ARaddr, Rready,
    output AWready, Wready, Bvalid, Bresp, ARready, Rvalid, Rdata, Rresp
  );

endinterface

// File: rtl/axil_wr_ctrl.sv
// Write-side controller: AW/W acceptance in either order, commit request to the
// register array, and the B response channel.
module axil_wr_ctrl
  import axil_pkg::*;
#(
  parameter int N_REGS = 16,
  localparam int IDX_W = $clog2(N_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  axil_if.slave            bus,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output data_t            wr_data,
  output strb_t            wr_strb
);

  wr_state_t  state;
  addr_t      aw_addr_q;
  data_t      w_data_q;
  strb_t      w_strb_q;
  logic       aw_hs;
  logic       w_hs;
  logic       commit;
  addr_t      c_addr;
  logic [1:0] c_resp;

  assign aw_hs = bus.AWvalid && bus.AWready;
  assign w_hs  = bus.Wvalid && bus.Wready;

  // Commit fires on the handshake completing the address/data pair, taking
  // whichever half arrives this cycle straight from the bus.
  always_comb begin
    commit  = 1'b0;
    c_addr  = aw_addr_q;
    wr_data = w_data_q;
    wr_strb = w_strb_q;
    case (state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit  = 1'b1;
          c_addr  = bus.AWaddr;
          wr_data = bus.Wdata;
          wr_strb = bus.Wstrb;
        end
      end
      W_GOT_ADDR: begin
        if (w_hs) begin
          commit  = 1'b1;
          wr_data = bus.Wdata;
          wr_strb = bus.Wstrb;
        end
      end
      W_GOT_DATA: begin
        if (aw_hs) begin
          commit = 1'b1;
          c_addr = bus.AWaddr;
        end
      end
      default: commit = 1'b0;
    endcase
  end

  assign wr_idx = c_addr[IDX_W+1:2];
  assign c_resp = (addr_err(c_addr, N_REGS) || (wr_idx == IDX_W'(N_REGS - 1)))
                  ? RESP_SLVERR : RESP_OKAY;
  assign wr_en  = commit && !rst && (c_resp == RESP_OKAY);

  // Readies are registered from the next state so no valid input reaches them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= W_IDLE;
      bus.AWready <= 1'b0;
      bus.Wready  <= 1'b0;
      bus.Bvalid  <= 1'b0;
      bus.Bresp   <= RESP_OKAY;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
    end else begin
      case (state)
        W_IDLE: begin
          if (commit) begin
            state       <= W_RESP;
            bus.AWready <= 1'b0;
            bus.Wready  <= 1'b0;
            bus.Bvalid  <= 1'b1;
            bus.Bresp   <= c_resp;
          end else if (aw_hs) begin
            state       <= W_GOT_ADDR;
            aw_addr_q   <= bus.AWaddr;
            bus.AWready <= 1'b0;
            bus.Wready  <= 1'b1;
          end else if (w_hs) begin
            state       <= W_GOT_DATA;
            w_data_q    <= bus.Wdata;
            w_strb_q    <= bus.Wstrb;
            bus.AWready <= 1'b1;
            bus.Wready  <= 1'b0;
          end else begin
            bus.AWready <= 1'b1;
            bus.Wready  <= 1'b1;
          end
        end
        W_GOT_ADDR, W_GOT_DATA: begin
          if (commit) begin
            state       <= W_RESP;
            bus.AWready <= 1'b0;
            bus.Wready  <= 1'b0;
            bus.Bvalid  <= 1'b1;
            bus.Bresp   <= c_resp;
          end
        end
        W_RESP: begin
          if (bus.Bready) begin
            state       <= W_IDLE;
            bus.Bvalid  <= 1'b0;
            bus.AWready <= 1'b1;
            bus.Wready  <= 1'b1;
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axil_regbank.sv
// AXI4-Lite register bank: N_REGS-1 read/write registers plus a read-only
// status word in the top slot; register 0 drives ctrl_o.
module axil_regbank
  import axil_pkg::*;
#(
  parameter int    N_REGS    = 16,
  parameter data_t RESET_VAL = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  rst,
  axil_if.slave bus,
  input  data_t status_i,
  output data_t ctrl_o
);

  localparam int IDX_W = $clog2(N_REGS);

  data_t            regs [N_REGS-1];
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  data_t            wr_data;
  strb_t            wr_strb;
  rd_state_t        rd_state;
  logic [IDX_W-1:0] rd_idx;
  data_t            rd_data;
  logic [1:0]       rd_resp;

  axil_wr_ctrl #(.N_REGS(N_REGS)) u_wr_ctrl (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REGS - 1; i++) regs[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < N_REGS - 1; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  assign ctrl_o = regs[0];
  assign rd_idx = bus.ARaddr[IDX_W+1:2];

  // Reads see the array before any same-cycle commit lands.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (addr_err(bus.ARaddr, N_REGS)) begin
      rd_resp = RESP_SLVERR;
    end else if (rd_idx == IDX_W'(N_REGS - 1)) begin
      rd_data = status_i;
    end else begin
      for (int i = 0; i < N_REGS - 1; i++) begin
        if (rd_idx == IDX_W'(i)) rd_data = regs[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state    <= R_IDLE;
      bus.ARready <= 1'b0;
      bus.Rvalid  <= 1'b0;
      bus.Rresp   <= RESP_OKAY;
      bus.Rdata   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (bus.ARvalid && bus.ARready) begin
            rd_state    <= R_RESP;
            bus.ARready <= 1'b0;
            bus.Rvalid  <= 1'b1;
            bus.Rdata   <= rd_data;
            bus.Rresp   <= rd_resp;
          end else begin
            bus.ARready <= 1'b1;
          end
        end
        R_RESP: begin
          if (bus.Rready) begin
            rd_state    <= R_IDLE;
            bus.Rvalid  <= 1'b0;
            bus.ARready <= 1'b1;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_regbank.sv
// Randomized bench for axil_regbank: drivers push expected responses, a
// monitor pops and compares them at every B/R handshake.
module tb_axil_regbank;
  import axil_pkg::*;

  localparam int    N_REGS    = 16;
  localparam data_t RESET_VAL = 32'h5A5A_0F0F;

  typedef struct {
    logic [1:0] resp;
    data_t      data;
  } rsp_t;

  logic  clk = 1'b0;
  logic  rst;
  data_t status;
  data_t ctrl;

  axil_if bus ();

  axil_regbank #(.N_REGS(N_REGS), .RESET_VAL(RESET_VAL)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .status_i (status),
    .ctrl_o   (ctrl)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  data_t      model [N_REGS];
  logic [1:0] b_exp [$];
  rsp_t       r_exp [$];

  task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: registers are plain words, status lives in the top slot.
  function automatic logic [1:0] model_write(addr_t a, data_t d, strb_t s);
    int idx;
    if (a >= 4 * N_REGS || a % 4 != 0) return RESP_SLVERR;
    idx = int'(a / 4);
    if (idx == N_REGS - 1) return RESP_SLVERR;
    for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    return RESP_OKAY;
  endfunction

  function automatic rsp_t model_read(addr_t a);
    rsp_t r;
    r.resp = RESP_OKAY;
    r.data = '0;
    if (a >= 4 * N_REGS || a % 4 != 0) r.resp = RESP_SLVERR;
    else if (int'(a / 4) == N_REGS - 1) r.data = status;
    else r.data = model[int'(a / 4)];
    return r;
  endfunction

  initial begin
    rsp_t       er;
    logic [1:0] eb;
    forever begin
      @(negedge clk);
      if (!rst && bus.Bvalid && bus.Bready) begin
        if (b_exp.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL b_unexpected: got Bresp %h, expected no response", bus.Bresp);
        end else begin
          eb = b_exp.pop_front();
          check_output("bresp", bus.Bresp, eb);
        end
      end
      if (!rst && bus.Rvalid && bus.Rready) begin
        if (r_exp.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL r_unexpected: got Rdata %h, expected no response", bus.Rdata);
        end else begin
          er = r_exp.pop_front();
          check_output("rresp", bus.Rresp, er.resp);
          check_output("rdata", bus.Rdata, er.data);
        end
      end
    end
  end

  task automatic send_aw(addr_t a, int dly, output logic ok);
    repeat (dly) begin @(posedge clk); #1; end
    bus.AWaddr  = a;
    bus.AWvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk); ok = bus.AWready;
      @(posedge clk); #1;
    end
    bus.AWvalid = 1'b0;
  endtask

  task automatic send_w(data_t d, strb_t s, int dly, output logic ok);
    repeat (dly) begin @(posedge clk); #1; end
    bus.Wdata  = d;
    bus.Wstrb  = s;
    bus.Wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk); ok = bus.Wready;
      @(posedge clk); #1;
    end
    bus.Wvalid = 1'b0;
  endtask

  task automatic send_ar(addr_t a, int dly, output logic ok);
    repeat (dly) begin @(posedge clk); #1; end
    bus.ARaddr  = a;
    bus.ARvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk); ok = bus.ARready;
      @(posedge clk); #1;
    end
    bus.ARvalid = 1'b0;
  endtask

  task automatic apply_stimulus_write(addr_t a, data_t d, strb_t s, int aw_dly, int w_dly, int b_dly);
    logic [1:0] eb;
    logic       ok_aw, ok_w, got;
    eb = model_write(a, d, s);
    b_exp.push_back(eb);
    fork
      send_aw(a, aw_dly, ok_aw);
      send_w(d, s, w_dly, ok_w);
    join
    check_output("aw_handshake", ok_aw, 1'b1);
    check_output("w_handshake", ok_w, 1'b1);
    check_output("bvalid_after_commit", bus.Bvalid, 1'b1);
    check_output("awready_in_resp", bus.AWready, 1'b0);
    check_output("wready_in_resp", bus.Wready, 1'b0);
    check_output("ctrl_after_commit", ctrl, model[0]);
    repeat (b_dly) begin
      @(negedge clk);
      check_output("bvalid_hold", bus.Bvalid, 1'b1);
      check_output("bresp_hold", bus.Bresp, eb);
      check_output("awready_hold", bus.AWready, 1'b0);
      check_output("wready_hold", bus.Wready, 1'b0);
      @(posedge clk); #1;
    end
    bus.Bready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); got = bus.Bvalid;
      @(posedge clk); #1;
    end
    bus.Bready = 1'b0;
    check_output("b_handshake", got, 1'b1);
  endtask

  task automatic issue_read(addr_t a, rsp_t e, int ar_dly, int r_dly);
    logic ok, got;
    r_exp.push_back(e);
    send_ar(a, ar_dly, ok);
    check_output("ar_handshake", ok, 1'b1);
    check_output("rvalid_latency", bus.Rvalid, 1'b1);
    check_output("arready_in_resp", bus.ARready, 1'b0);
    status = $urandom;
    repeat (r_dly) begin
      @(negedge clk);
      check_output("rvalid_hold", bus.Rvalid, 1'b1);
      check_output("rdata_hold", bus.Rdata, e.data);
      check_output("rresp_hold", bus.Rresp, e.resp);
      @(posedge clk); #1;
    end
    bus.Rready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); got = bus.Rvalid;
      @(posedge clk); #1;
    end
    bus.Rready = 1'b0;
    check_output("r_handshake", got, 1'b1);
  endtask

  task automatic apply_stimulus_read(addr_t a, int ar_dly, int r_dly);
    rsp_t e;
    e = model_read(a);
    issue_read(a, e, ar_dly, r_dly);
  endtask

  initial begin
    rsp_t  e;
    addr_t a;
    int    sel;
    logic  ok;

    rst = 1'b1;
    bus.AWvalid = 1'b0; bus.AWaddr = '0;
    bus.Wvalid  = 1'b0; bus.Wdata  = '0; bus.Wstrb = '0;
    bus.Bready  = 1'b0;
    bus.ARvalid = 1'b0; bus.ARaddr = '0;
    bus.Rready  = 1'b0;
    status = '0;
    for (int i = 0; i < N_REGS; i++) model[i] = RESET_VAL;

    repeat (3) begin @(posedge clk); #1; end
    check_output("rst_awready", bus.AWready, 1'b0);
    check_output("rst_wready", bus.Wready, 1'b0);
    check_output("rst_arready", bus.ARready, 1'b0);
    check_output("rst_bvalid", bus.Bvalid, 1'b0);
    check_output("rst_rvalid", bus.Rvalid, 1'b0);
    check_output("rst_bresp", bus.Bresp, 2'b00);
    check_output("rst_rresp", bus.Rresp, 2'b00);
    check_output("rst_rdata", bus.Rdata, 32'h0);
    check_output("rst_ctrl", ctrl, RESET_VAL);
    rst = 1'b0;
    @(posedge clk); #1;
    check_output("post_rst_awready", bus.AWready, 1'b1);
    check_output("post_rst_wready", bus.Wready, 1'b1);
    check_output("post_rst_arready", bus.ARready, 1'b1);

    apply_stimulus_write(32'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    apply_stimulus_read(32'h04, 0, 0);

    apply_stimulus_write(32'h00, 32'hAAAA_AAAA, 4'hF, 0, 0, 0);
    apply_stimulus_write(32'h00, 32'h1122_3344, 4'h5, 3, 0, 0);
    check_output("strobe_merge_ctrl", ctrl, 32'hAA22_AA44);

    apply_stimulus_write(32'h08, 32'h0BAD_F00D, 4'hF, 0, 0, 5);

    apply_stimulus_write(32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    apply_stimulus_read(32'h02, 0, 1);
    apply_stimulus_write(32'h3C, 32'h1234_5678, 4'hF, 1, 0, 0);
    status = 32'hCAFE_0001;
    apply_stimulus_read(32'h3C, 0, 2);

    apply_stimulus_write(32'h04, 32'h1234_5678, 4'h0, 1, 0, 0);
    apply_stimulus_read(32'h04, 0, 0);

    // Read and commit to the same register in one cycle: read sees the old word.
    e = model_read(32'h0C);
    fork
      issue_read(32'h0C, e, 0, 0);
      apply_stimulus_write(32'h0C, 32'h0F0F_1234, 4'hF, 0, 0, 0);
    join
    apply_stimulus_read(32'h0C, 0, 0);

    // Reset with a read response pending and a write address latched.
    send_ar(32'h04, 0, ok);
    check_output("pend_ar_handshake", ok, 1'b1);
    send_aw(32'h00, 0, ok);
    check_output("pend_aw_handshake", ok, 1'b1);
    check_output("pend_rvalid", bus.Rvalid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_output("mid_rst_rvalid", bus.Rvalid, 1'b0);
    check_output("mid_rst_bvalid", bus.Bvalid, 1'b0);
    check_output("mid_rst_ctrl", ctrl, RESET_VAL);
    rst = 1'b0;
    for (int i = 0; i < N_REGS; i++) model[i] = RESET_VAL;
    @(posedge clk); #1;
    check_output("mid_rst_awready", bus.AWready, 1'b1);
    check_output("mid_rst_arready", bus.ARready, 1'b1);
    apply_stimulus_write(32'h08, 32'h7777_1111, 4'hF, 2, 0, 0);
    apply_stimulus_read(32'h00, 0, 0);
    apply_stimulus_read(32'h08, 0, 0);

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8) a = addr_t'($urandom_range(0, N_REGS - 1)) << 2;
      else if (sel == 8) a = (addr_t'($urandom_range(0, N_REGS - 1)) << 2) | addr_t'($urandom_range(1, 3));
      else a = $urandom | 32'h40;
      if ($urandom_range(0, 1) == 1) begin
        apply_stimulus_write(a, $urandom, strb_t'($urandom_range(0, 15)),
                             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        status = $urandom;
        apply_stimulus_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    for (int i = 0; i < N_REGS; i++) begin
      status = $urandom;
      apply_stimulus_read(addr_t'(i * 4), 0, 0);
    end

    check_output("b_queue_drained", b_exp.size(), 0);
    check_output("r_queue_drained", r_exp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_regbank.md
AXIL_REGBANK -- requirements
Module: axil_regbank

Interface
REQ-001 Parameter N_REGS, default 16, number of 32-bit registers; index = addr[5:2].
REQ-002 Parameter RESET_VAL, default 32'h0000_0000, reset value of every read/write register.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 AWvalid/AWready/AWaddr  in/out/in  1/1/32  write address channel.
REQ-006 Wvalid/Wready/Wdata/Wstrb  in/out/in/in  1/1/32/4  write data channel with byte strobes.
REQ-007 Bvalid/Bready/Bresp  out/in/out  1/1/2  write response channel.
REQ-008 ARvalid/ARready/ARaddr  in/out/in  1/1/32  read address channel.
REQ-009 Rvalid/Rready/Rdata/Rresp  out/in/out/out  1/1/32/2  read data channel.
REQ-010 status_i  input  32  value returned on reads of register N_REGS-1, the read-only status register.
REQ-011 ctrl_o  output  32  current contents of register 0.

Function
REQ-012 The block is an AXI4-Lite responder: one outstanding write and one outstanding read, with independent write and read paths.
REQ-013 Write FSM states: W_IDLE, W_GOT_ADDR, W_GOT_DATA, W_RESP.
REQ-014 Ready outputs: AWready=1 in W_IDLE and W_GOT_DATA; Wready=1 in W_IDLE and W_GOT_ADDR; both 0 in W_RESP.
REQ-015 W_IDLE transitions:
- AW and W both handshake in the same cycle -> commit, go to W_RESP;
- AW only -> latch AWaddr, go to W_GOT_ADDR;
- W only -> latch Wdata and Wstrb, go to W_GOT_DATA.
REQ-016 W_GOT_ADDR + W handshake, or W_GOT_DATA + AW handshake -> commit, go to W_RESP.
REQ-017 Commit: for each byte b with Wstrb[b]=1, reg[idx][8b+7:8b] <= Wdata[8b+7:8b]; bytes with strobe 0 are unchanged; Wstrb=0 is a legal no-op with response OKAY.
REQ-018 Bvalid rises in the cycle after commit and holds, with Bresp stable, until Bready=1; then go to W_IDLE; the next AW/W is accepted no earlier than the following cycle.
REQ-019 Read FSM states: R_IDLE (ARready=1) and R_RESP (ARready=0, Rvalid=1).
REQ-020 AR handshake latches Rdata/Rresp; Rvalid rises the next cycle (1-cycle latency) and holds, with data stable, until Rready=1; then go to R_IDLE.
REQ-021 Error decode, AW and AR alike: address >= 4*N_REGS, or addr[1:0] != 0 -> response SLVERR (2'b10).
- Write: no register changes.
- Read: Rdata = 0.
REQ-022 A write to register N_REGS-1 -> SLVERR, no state change; a read of it returns status_i sampled at the AR handshake, with OKAY.
REQ-023 All other accesses -> OKAY (2'b00).
REQ-024 A read handshake in the same cycle as a write commit to the same register returns the pre-write value.
REQ-025 ctrl_o reflects a commit to register 0 in the cycle after the commit.
REQ-026 Bvalid/Rvalid stay asserted regardless of AWvalid/Wvalid/ARvalid activity; no combinational path from any *valid input to any *ready output.

Reset
REQ-027 While rst=1 at posedge clk, the following take these values:
- both FSMs -> W_IDLE / R_IDLE;
- AWready=Wready=ARready=0;
- Bvalid=Rvalid=0, Bresp=Rresp=0, Rdata=0;
- every read/write register -> RESET_VAL, so ctrl_o=RESET_VAL.
REQ-028 In the first cycle after rst deasserts, AWready=Wready=ARready=1.
REQ-029 Reset mid-transaction abandons it: any pending B/R response is dropped, latched address/data are discarded, and no partial commit occurs.

Structure
REQ-030 Shared package axil_pkg holds:
- RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
- the write-FSM and read-FSM state enums;
- the typedefs addr_t (32b), data_t (32b) and strb_t (4b).
REQ-031 One sub-module, axil_wr_ctrl, implements the write FSM, the AW/W latches and the B channel; the register array and the read path stay in axil_regbank.

Verification
REQ-032 AW=0x04 and W=0xDEADBEEF, strb 0xF, in the same cycle -> Bvalid next cycle with OKAY; a subsequent read of 0x04 returns Rdata=0xDEADBEEF with OKAY, 1 cycle after AR.
REQ-033 W=0x11223344, strb 0x5, 3 cycles before AW=0x00 over a reg0 value of 0xAAAAAAAA -> reg0=0xAA22AA44, ctrl_o updates the cycle after commit.
REQ-034 Bready held low for 5 cycles -> Bvalid/Bresp stable for those cycles; AWready=Wready=0 throughout; new AW is accepted only after the B handshake.
REQ-035 AW=0x40 (write) and AR=0x02 (read) -> both SLVERR, Rdata=0, no register changed.
REQ-036 Write to 0x3C -> SLVERR; read of 0x3C with status_i=0xCAFE0001 -> 0xCAFE0001 with OKAY.
REQ-037 rst asserted while Rvalid=1 and W_GOT_ADDR is pending -> next cycle Rvalid=0, Bvalid=0, ctrl_o=RESET_VAL; the following transaction completes normally.
